// File: rtl/change_pkg.sv
// Shared state encoding and coin values for the change dispenser.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WAIT10 = 3'd2,
    WAIT5  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int COIN_HI = 10;
  localparam int COIN_LO = 5;

endpackage

// File: rtl/ack_timer.sv
// Hopper ack watchdog: counts while enabled and flags the last allowed cycle.
module ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 8'd1;
  end

  // The TIMEOUT-th enabled cycle is the last one; expiry is seen within it.
  assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Pays a requested amount out of the hopper as 10- and 5-unit coins, greedy,
// reporting any unpaid remainder and ack timeouts.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             eject_10,
  output logic             eject_5,
  input  logic             hop_ack,
  input  logic             empty_10,
  input  logic             empty_5,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] short_amount,
  output logic             fault
);

  localparam logic [AMT_W-1:0] HI = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] LO = AMT_W'(COIN_LO);

  state_t           state, next;
  logic [AMT_W-1:0] remaining;
  logic             in_wait, expired, accept;

  assign in_wait   = (state == WAIT10) || (state == WAIT5);
  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_wait && (hop_ack || expired)),
    .enable  (in_wait),
    .expired (expired)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (req_valid) next = SELECT;
      SELECT: begin
        if (remaining >= HI && !empty_10)     next = WAIT10;
        else if (remaining >= LO && !empty_5) next = WAIT5;
        else                                  next = FINISH;
      end
      WAIT10, WAIT5: begin
        if (hop_ack)      next = SELECT;
        else if (expired) next = FINISH;
      end
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining    <= '0;
      eject_10     <= 1'b0;
      eject_5      <= 1'b0;
      short_amount <= '0;
      fault        <= 1'b0;
    end else begin
      eject_10 <= (state == SELECT) && (next == WAIT10);
      eject_5  <= (state == SELECT) && (next == WAIT5);
      if (accept) begin
        remaining    <= req_amount;
        fault        <= 1'b0;
        short_amount <= '0;
      end else if (state == WAIT10 && hop_ack) begin
        remaining <= remaining - HI;
      end else if (state == WAIT5 && hop_ack) begin
        remaining <= remaining - LO;
      end
      if (in_wait && !hop_ack && expired) fault <= 1'b1;
      // remaining never changes on entry to FINISH, so the result is ready in the done cycle
      if (next == FINISH && state != FINISH) short_amount <= remaining;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a behavioural hopper and a result scoreboard.
module tb_change_dispenser;
  localparam int AMT_W = 8, TIMEOUT = 15;

  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, hop_ack = 1'b0;
  logic empty_10 = 1'b0, empty_5 = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic req_ready, eject_10, eject_5, busy, done, fault;
  logic [AMT_W-1:0] short_amount;

  change_dispenser #(.AMT_W(AMT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .eject_10(eject_10), .eject_5(eject_5), .hop_ack(hop_ack),
    .empty_10(empty_10), .empty_5(empty_5), .busy(busy), .done(done),
    .short_amount(short_amount), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {int n10; int n5; int short_amt; int flt; int lat;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cnt10 = 0, cnt5 = 0;
  bit ack_en = 1'b0, ack_force = 1'b0, prev_ej = 1'b0;

  // Hopper: acks during the cycle after each eject when enabled.
  always @(negedge clk) begin
    hop_ack = ack_force | (ack_en & prev_ej);
    prev_ej = eject_10 | eject_5;
    cnt10 += int'(eject_10);
    cnt5  += int'(eject_5);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input bit e10, input bit e5, input bit ack);
    exp_t r;
    int rem = a;
    r = '{0, 0, 0, 0, 0};
    if (!ack) begin
      if (rem >= 10 && !e10)     begin r.n10 = 1; r.flt = 1; end
      else if (rem >= 5 && !e5)  begin r.n5 = 1;  r.flt = 1; end
      r.short_amt = rem;
      r.lat = r.flt ? TIMEOUT + 2 : 2;
      return r;
    end
    forever begin
      if (rem >= 10 && !e10)    begin rem -= 10; r.n10++; end
      else if (rem >= 5 && !e5) begin rem -= 5;  r.n5++;  end
      else break;
    end
    r.short_amt = rem;
    r.lat = 3 * (r.n10 + r.n5) + 2;
    return r;
  endfunction

  task automatic send(input int a, input bit hold);
    @(posedge clk); #1;
    req_amount = a[AMT_W-1:0];
    req_valid  = 1'b1;
    sb.push_back(model(a, empty_10, empty_5, ack_en));
    @(negedge clk);
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    cnt10 = 0; cnt5 = 0;
  endtask

  task automatic finish_req(input string tag, input int start);
    exp_t e = sb.pop_front();
    int cyc = start;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 300);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_short"}, short_amount, e.short_amt);
    chk({tag, "_fault"}, fault, e.flt);
    chk({tag, "_n10"}, cnt10, e.n10);
    chk({tag, "_n5"}, cnt5, e.n5);
  endtask

  initial begin
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ej10", eject_10, 0);
    chk("rst_ej5", eject_5, 0);
    chk("rst_short", short_amount, 0);
    chk("rst_fault", fault, 0);
    @(posedge clk); #1 rst = 1'b1;

    ack_en = 1'b1;
    send(15, 0);  finish_req("exact15", 0);
    send(3, 0);   finish_req("amt3", 0);
    empty_10 = 1'b1;
    send(27, 0);  finish_req("amt27_e10", 0);
    empty_10 = 1'b0; empty_5 = 1'b1;
    send(17, 0);  finish_req("amt17_e5", 0);
    empty_5 = 1'b0;
    send(45, 0);  finish_req("amt45", 0);

    // Timeout on first request; second request held on req_valid behind it.
    ack_en = 1'b0;
    send(20, 1);  finish_req("tmo20", 0);
    req_amount = 8'd15;
    ack_en = 1'b1;
    sb.push_back(model(15, empty_10, empty_5, 1'b1));
    @(negedge clk);
    chk("hold_idle_ready", req_ready, 1);
    chk("hold_idle_fault", fault, 1);
    chk("hold_idle_short", short_amount, 20);
    @(negedge clk);
    req_valid = 1'b0;
    cnt10 = 0; cnt5 = 0;
    chk("hold_acc_busy", busy, 1);
    chk("hold_acc_fault", fault, 0);
    chk("hold_acc_short", short_amount, 0);
    finish_req("held15", 1);

    // Reset in the middle of a WAIT10.
    ack_en = 1'b0;
    send(30, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ej10", eject_10, 0);
    chk("mid_rst_ej5", eject_5, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_short", short_amount, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_ready", req_ready, 1);
    void'(sb.pop_front());
    @(posedge clk); #1 rst = 1'b1;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_short", short_amount, 0);
    ack_en = 1'b1;
    send(15, 0);  finish_req("post_rst15", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
